kb_cmd_ctrl: RTL and testbench



---
 rtl/kb_cmd_ctrl.sv | 174 +++++++++++++++++
 tb/tb_kb_cmd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : kb_cmd_ctrl
//  Purpose  : Queues PS/2 set-2 make codes from kb_code in a small circular
//             FIFO. It then takes them one at a time through a three-state
//             engine (IDLE -> DECODE -> PRESENT). Codes for digits, Enter,
//             Backspace and Escape become 4-bit commands. Each command is
//             offered with a valid/ready handshake. All other codes are
//             dropped silently.
//  Ports    : clk            - system clock, rising edge
//             reset          - synchronous, active-high
//             got_code_tick  - one-cycle strobe, key_code valid
//             key_code[7:0]  - raw make code
//             cmd_ready      - consumer takes cmd_code this cycle
//             cmd_valid      - cmd_code holds a command
//             cmd_code[3:0]  - decoded command (0-9, A=Enter, B=Bksp, C=Esc)
//             fifo_count[2:0]- raw codes currently queued (0..4)
//             overflow       - sticky, a code was dropped on a full queue
//  Revision : 1.0  initial release
// ============================================================================
module kb_cmd_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       got_code_tick,
   input  logic [7:0] key_code,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [3:0] cmd_code,
   output logic [2:0] fifo_count,
   output logic       overflow
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DECODE  = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] fifo_q [FIFO_DEPTH];
   logic [7:0] fifo_d [FIFO_DEPTH];
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic [7:0] code_reg_q, code_reg_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic [3:0] cmd_code_q, cmd_code_d;
   logic       overflow_q, overflow_d;

   logic       pop;
   logic       push;
   logic       full;
   logic       dec_hit;
   logic [3:0] dec_cmd;

   // Set-2 make code to command table.
   always_comb begin
      dec_hit = 1'b1;
      dec_cmd = 4'h0;
      case (code_reg_q)
         8'h45:   dec_cmd = 4'h0;
         8'h16:   dec_cmd = 4'h1;
         8'h1E:   dec_cmd = 4'h2;
         8'h26:   dec_cmd = 4'h3;
         8'h25:   dec_cmd = 4'h4;
         8'h2E:   dec_cmd = 4'h5;
         8'h36:   dec_cmd = 4'h6;
         8'h3D:   dec_cmd = 4'h7;
         8'h3E:   dec_cmd = 4'h8;
         8'h46:   dec_cmd = 4'h9;
         8'h5A:   dec_cmd = 4'hA;
         8'h66:   dec_cmd = 4'hB;
         8'h76:   dec_cmd = 4'hC;
         default: dec_hit = 1'b0;
      endcase
   end

   // Command engine: next state and outputs.
   always_comb begin
      state_d     = state_q;
      code_reg_d  = code_reg_q;
      cmd_valid_d = cmd_valid_q;
      cmd_code_d  = cmd_code_q;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != 3'd0) begin
               pop        = 1'b1;
               code_reg_d = fifo_q[rd_ptr_q];
               state_d    = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_hit) begin
               cmd_code_d  = dec_cmd;
               cmd_valid_d = 1'b1;
               state_d     = ST_PRESENT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRESENT: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A pop frees a slot on this same edge, so a full queue still accepts
   // a tick that coincides with a pop.
   always_comb begin
      full       = (count_q == 3'(FIFO_DEPTH));
      push       = got_code_tick && (!full || pop);
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         fifo_d[wr_ptr_q] = key_code;
         wr_ptr_d         = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
      if (got_code_tick && full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         count_q     <= 3'd0;
         code_reg_q  <= 8'd0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= 4'd0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         code_reg_q  <= code_reg_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         overflow_q  <= overflow_d;
      end
   end

   // Queue storage needs no reset; only entries behind the pointers are read.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_code   = cmd_code_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_kb_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kb_cmd_ctrl
//  Purpose  : Self-checking bench for kb_cmd_ctrl. It covers a decode table,
//             directed multi-cycle scenarios and a long randomized run.
//             A queue-based reference model is compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kb_cmd_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       got_code_tick;
   logic [7:0] key_code;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [3:0] cmd_code;
   logic [2:0] fifo_count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   kb_cmd_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .got_code_tick (got_code_tick),
      .key_code      (key_code),
      .cmd_ready     (cmd_ready),
      .cmd_valid     (cmd_valid),
      .cmd_code      (cmd_code),
      .fifo_count    (fifo_count),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Command table: -1 means the code carries no command.
   function automatic int map_code(input logic [7:0] c);
      case (c)
         8'h45: return 0;   8'h16: return 1;   8'h1E: return 2;
         8'h26: return 3;   8'h25: return 4;   8'h2E: return 5;
         8'h36: return 6;   8'h3D: return 7;   8'h3E: return 8;
         8'h46: return 9;   8'h5A: return 10;  8'h66: return 11;
         8'h76: return 12;
         default: return -1;
      endcase
   endfunction

   // ---------------- reference model ----------------
   // mq: raw codes waiting; m_flight: code taken from the queue and being
   // looked up (-1 none); m_hold: command on offer (-1 none).
   logic [7:0] mq[$];
   int         m_flight = -1;
   int         m_hold   = -1;
   int         m_code   = 0;
   int         m_ovf    = 0;
   bit         chk_en   = 1'b0;
   int         old_flight, old_hold, mc;
   bit         eng_free;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_flight = -1;
         m_hold   = -1;
         m_code   = 0;
         m_ovf    = 0;
         chk_en   = 1'b1;
      end else begin
         old_flight = m_flight;
         old_hold   = m_hold;
         eng_free   = (old_flight < 0) && (old_hold < 0);
         if (old_hold >= 0 && cmd_ready) m_hold = -1;
         m_flight = -1;
         if (old_flight >= 0) begin
            mc = map_code(old_flight[7:0]);
            if (mc >= 0) begin
               m_hold = mc;
               m_code = mc;
            end
         end
         if (eng_free && mq.size() > 0) m_flight = int'(mq.pop_front());
         if (got_code_tick) begin
            if (mq.size() < 4) mq.push_back(key_code);
            else m_ovf = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_valid", int'(cmd_valid), int'(m_hold >= 0));
         chk("model_code", int'(cmd_code), m_code);
         chk("model_count", int'(fifo_count), mq.size());
         chk("model_ovf", int'(overflow), m_ovf);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at a negedge: drive inputs, consume one rising edge, return at
   // the following negedge with outputs settled.
   task automatic cyc(input logic t, input logic [7:0] c, input logic r, input logic rst);
      got_code_tick = t;
      key_code      = c;
      cmd_ready     = r;
      reset         = rst;
      @(negedge clk);
   endtask

   logic [3:0] seen[$];
   int         expq[$];

   task automatic drain(input int n);
      seen.delete();
      for (int i = 0; i < n; i++) begin
         if (cmd_valid) seen.push_back(cmd_code);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
   endtask

   task automatic cmp_seen(input string name);
      chk({name, "_n"}, seen.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         if (i < seen.size()) chk({name, "_cmd"}, int'(seen[i]), expq[i]);
      end
   endtask

   typedef struct {
      logic [7:0] code;
      logic       exp_valid;
      logic [3:0] exp_code;
   } vec_t;

   vec_t vecs [18];
   int   nvalid;
   logic [7:0] pick;
   logic [7:0] mapped_codes [13];

   initial begin
      vecs[0]  = '{8'h45, 1'b1, 4'h0};  vecs[1]  = '{8'h16, 1'b1, 4'h1};
      vecs[2]  = '{8'h1E, 1'b1, 4'h2};  vecs[3]  = '{8'h26, 1'b1, 4'h3};
      vecs[4]  = '{8'h25, 1'b1, 4'h4};  vecs[5]  = '{8'h2E, 1'b1, 4'h5};
      vecs[6]  = '{8'h36, 1'b1, 4'h6};  vecs[7]  = '{8'h3D, 1'b1, 4'h7};
      vecs[8]  = '{8'h3E, 1'b1, 4'h8};  vecs[9]  = '{8'h46, 1'b1, 4'h9};
      vecs[10] = '{8'h5A, 1'b1, 4'hA};  vecs[11] = '{8'h66, 1'b1, 4'hB};
      vecs[12] = '{8'h76, 1'b1, 4'hC};  vecs[13] = '{8'hF0, 1'b0, 4'h0};
      vecs[14] = '{8'hE0, 1'b0, 4'h0};  vecs[15] = '{8'h1C, 1'b0, 4'h0};
      vecs[16] = '{8'h00, 1'b0, 4'h0};  vecs[17] = '{8'hFF, 1'b0, 4'h0};
      for (int i = 0; i < 13; i++) mapped_codes[i] = vecs[i].code;

      reset = 1'b1; got_code_tick = 1'b0; key_code = 8'h00; cmd_ready = 1'b0;
      @(negedge clk);
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_code", int'(cmd_code), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ovf", int'(overflow), 0);

      // Decode table: result visible after the second edge past the tick.
      for (int i = 0; i < 18; i++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b1);
         cyc(1'b1, vecs[i].code, 1'b1, 1'b0);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("tbl_valid", int'(cmd_valid), int'(vecs[i].exp_valid));
         chk("tbl_code", int'(cmd_code), int'(vecs[i].exp_code));
      end

      // Single digit: fixed latency and one-cycle valid under ready=1.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'h45, 1'b1, 1'b0);
      chk("sd_cnt_n", int'(fifo_count), 1);
      chk("sd_val_n", int'(cmd_valid), 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("sd_cnt_n1", int'(fifo_count), 0);
      chk("sd_val_n1", int'(cmd_valid), 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("sd_val_n2", int'(cmd_valid), 1);
      chk("sd_code_n2", int'(cmd_code), 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("sd_val_n3", int'(cmd_valid), 0);

      // Backpressure: first command held, rest queued in order.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'h16, 1'b0, 1'b0);
      cyc(1'b1, 8'h1E, 1'b0, 1'b0);
      cyc(1'b1, 8'h26, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b0);
         chk("bp_valid", int'(cmd_valid), 1);
         chk("bp_code", int'(cmd_code), 1);
         chk("bp_count", int'(fifo_count), 2);
      end
      drain(15);
      expq = '{1, 2, 3};
      cmp_seen("bp");

      // Unmapped filter: only Enter produces a command.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      seen.delete();
      for (int i = 0; i < 3; i++) begin
         if (cmd_valid) seen.push_back(cmd_code);
         pick = (i == 0) ? 8'hF0 : (i == 1) ? 8'h1C : 8'h5A;
         cyc(1'b1, pick, 1'b1, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         if (cmd_valid) seen.push_back(cmd_code);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      expq = '{10};
      cmp_seen("unm");

      // Overflow: sixth tick lost on a full queue.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'h45, 1'b0, 1'b0);
      cyc(1'b1, 8'h16, 1'b0, 1'b0);
      cyc(1'b1, 8'h1E, 1'b0, 1'b0);
      cyc(1'b1, 8'h26, 1'b0, 1'b0);
      cyc(1'b1, 8'h25, 1'b0, 1'b0);
      chk("ov_pre_ovf", int'(overflow), 0);
      cyc(1'b1, 8'h36, 1'b0, 1'b0);
      chk("ov_count", int'(fifo_count), 4);
      chk("ov_flag", int'(overflow), 1);
      drain(25);
      expq = '{0, 1, 2, 3, 4};
      cmp_seen("ov");
      chk("ov_sticky", int'(overflow), 1);

      // Full plus pop: tick coincides with the IDLE pop on a full queue.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'h45, 1'b0, 1'b0);
      cyc(1'b1, 8'h16, 1'b0, 1'b0);
      cyc(1'b1, 8'h1E, 1'b0, 1'b0);
      cyc(1'b1, 8'h26, 1'b0, 1'b0);
      cyc(1'b1, 8'h25, 1'b0, 1'b0);
      chk("fp_full", int'(fifo_count), 4);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fp_idle_valid", int'(cmd_valid), 0);
      cyc(1'b1, 8'h76, 1'b0, 1'b0);
      chk("fp_count", int'(fifo_count), 4);
      chk("fp_ovf", int'(overflow), 0);
      drain(25);
      expq = '{1, 2, 3, 4, 12};
      cmp_seen("fp");

      // Mid-operation reset while presenting with two queued.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'h45, 1'b0, 1'b0);
      cyc(1'b1, 8'h16, 1'b0, 1'b0);
      cyc(1'b1, 8'h1E, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("mr_pre_valid", int'(cmd_valid), 1);
      chk("mr_pre_count", int'(fifo_count), 2);
      cyc(1'b1, 8'h46, 1'b1, 1'b1);
      chk("mr_valid", int'(cmd_valid), 0);
      chk("mr_count", int'(fifo_count), 0);
      chk("mr_ovf", int'(overflow), 0);
      chk("mr_code", int'(cmd_code), 0);
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         if (cmd_valid) nvalid++;
      end
      chk("mr_no_cmd", nvalid, 0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) pick = 8'($urandom);
         else pick = mapped_codes[$urandom_range(0, 12)];
         cyc(1'($urandom_range(0, 99) < 40), pick, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
